// File: rtl/mem_block_ctrl_if.sv
// Memory-side bus of the block controller: single-port word memory, 1-cycle registered read.
// Combinational bundle only; no flow control, one access per cycle.
`timescale 1ns/1ps
interface mem_block_ctrl_if #(
  parameter int ADDR       = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_r_w;
  logic [ADDR-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (output mem_r_w, output mem_addr, output mem_din, input mem_dout);
  modport slave  (input mem_r_w, input mem_addr, input mem_din, output mem_dout);
endinterface

// File: rtl/mem_block_ctrl.sv
// Burst block mover between a word memory and a wide register; MEM_BLOCK_CTRL_WORD_REVERSE_EN flips word order.
// Read done at start+WORDS+2, write done at start+WORDS+1; starts outside IDLE are dropped, no backpressure.
`timescale 1ns/1ps
module mem_block_ctrl #(
  parameter int ADDR       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_read,
  input  logic                        start_write,
  input  logic [ADDR-1:0]             base_addr,
  input  logic [WORDS*DATA_WIDTH-1:0] block_in,
  output logic [WORDS*DATA_WIDTH-1:0] block_out,
  output logic                        busy,
  output logic                        done,
  mem_block_ctrl_if.master            mem
);

  localparam int CW = $clog2(WORDS + 1);
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [2:0] {IDLE, READ, READ_TAIL, WRITE, DONE} state_t;

  state_t                              state, state_nxt;
  logic   [CW-1:0]                     cnt;
  logic   [ADDR-1:0]                   base_q;
  logic   [WORDS-1:0][DATA_WIDTH-1:0]  rd_words;
  logic   [WORDS-1:0][DATA_WIDTH-1:0]  wr_words;
  logic                                last;
  logic   [IW-1:0]                     rd_k, wr_k, rd_slot, wr_slot;

  assign last = (cnt == CW'(WORDS - 1));
  // Read data trails the address by one cycle, so the captured word is cnt-1.
  assign rd_k = (state == READ_TAIL) ? IW'(WORDS - 1) : IW'(cnt - CW'(1));
  assign wr_k = IW'(cnt);

`ifdef MEM_BLOCK_CTRL_WORD_REVERSE_EN
  assign rd_slot = IW'(WORDS - 1) - rd_k;
  assign wr_slot = IW'(WORDS - 1) - wr_k;
`else
  assign rd_slot = rd_k;
  assign wr_slot = wr_k;
`endif

  assign block_out = rd_words;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    mem.mem_r_w  = 1'b0;
    mem.mem_addr = '0;
    mem.mem_din  = '0;
    case (state)
      IDLE: begin
        if (start_read)       state_nxt = READ;
        else if (start_write) state_nxt = WRITE;
      end
      READ: begin
        mem.mem_addr = base_q + ADDR'(cnt);
        if (last) state_nxt = READ_TAIL;
      end
      READ_TAIL: begin
        mem.mem_addr = base_q + ADDR'(WORDS - 1);
        state_nxt    = DONE;
      end
      WRITE: begin
        mem.mem_r_w  = 1'b1;
        mem.mem_addr = base_q + ADDR'(cnt);
        mem.mem_din  = wr_words[wr_slot];
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      base_q   <= '0;
      rd_words <= '0;
      wr_words <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_read || start_write) begin
            base_q <= base_addr;
            cnt    <= '0;
            if (!start_read) wr_words <= block_in;
          end
        end
        READ: begin
          cnt <= cnt + CW'(1);
          if (cnt != '0) rd_words[rd_slot] <= mem.mem_dout;
        end
        READ_TAIL: rd_words[rd_slot] <= mem.mem_dout;
        WRITE:     cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl with a behavioural 16-word memory; vector table plus corner sequences.
`timescale 1ns/1ps
module tb_mem_block_ctrl;

  localparam int ADDR  = 4;
  localparam int DW    = 32;
  localparam int WORDS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_read = 1'b0;
  logic             start_write = 1'b0;
  logic [ADDR-1:0]  base_addr = '0;
  logic [127:0]     block_in = '0;
  logic [127:0]     block_out;
  logic             busy;
  logic             done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_block_ctrl_if #(.ADDR(ADDR), .DATA_WIDTH(DW)) mem_if ();

  mem_block_ctrl #(.ADDR(ADDR), .DATA_WIDTH(DW), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_read  (start_read),
    .start_write (start_write),
    .base_addr   (base_addr),
    .block_in    (block_in),
    .block_out   (block_out),
    .busy        (busy),
    .done        (done),
    .mem         (mem_if)
  );

  // Memory model: registered read, write when r_w=1; preload port for setup.
  logic [31:0] mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;

  always @(posedge clk) begin
    if (pl_en)                mem[pl_addr] <= pl_dat;
    else if (mem_if.mem_r_w)  mem[mem_if.mem_addr] <= mem_if.mem_din;
    mem_if.mem_dout <= mem[mem_if.mem_addr];
  end

  function automatic logic [127:0] order(input logic [127:0] b);
    logic [127:0] r;
    r = b;
`ifdef MEM_BLOCK_CTRL_WORD_REVERSE_EN
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = b[(3-k)*32 +: 32];
`endif
    return r;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [3:0]   base;
    logic [127:0] blk;
    logic [127:0] exp;   // read: block_out; write: memory words LSB-first
    int           lat;
  } vec_t;

  vec_t vecs[6];

  localparam logic [127:0] K = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] W = 128'hDEADBEEF_CAFEBABE_01234567_89ABCDEF;
  localparam logic [127:0] X = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

  task automatic run_xfer(input vec_t v);
    int         lat;
    logic [3:0] ea;
    lat = 0;
    @(posedge clk); #1;
    start_read = v.rd; start_write = v.wr; base_addr = v.base; block_in = v.blk;
    @(posedge clk); #1;
    start_read = 1'b0; start_write = 1'b0; base_addr = ~v.base; block_in = ~v.blk;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_after_start", busy, 1);
      check("mem_r_w", mem_if.mem_r_w, (!v.rd && c <= WORDS));
      if (c <= WORDS) begin
        ea = v.base + 4'(c - 1);
        check("mem_addr", mem_if.mem_addr, ea);
      end
      if (done) lat = c;
    end
    check("done_latency", lat, v.lat);
    if (v.rd) check("block_out", block_out, v.exp);
    else for (int k = 0; k < 4; k++) check("mem_word", mem[4'(v.base + 4'(k))], v.exp[k*32 +: 32]);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_back_idle", busy, 0);
    if (v.rd) check("block_hold", block_out, v.exp);
  endtask

  initial begin
    logic [127:0] ord_w;
    logic [31:0]  m8_exp;
    int           lat;
    int           npulse;

    vecs[0] = '{rd:1'b1, wr:1'b0, base:4'd2,  blk:'0, exp:order(K), lat:6};
    vecs[1] = '{rd:1'b0, wr:1'b1, base:4'd8,  blk:W,  exp:order(W), lat:5};
    vecs[2] = '{rd:1'b1, wr:1'b0, base:4'd8,  blk:'0, exp:W,        lat:6};
    vecs[3] = '{rd:1'b0, wr:1'b1, base:4'd14, blk:X,  exp:order(X), lat:5};
    vecs[4] = '{rd:1'b1, wr:1'b0, base:4'd14, blk:'0, exp:X,        lat:6};
    vecs[5] = '{rd:1'b1, wr:1'b1, base:4'd2,  blk:W,  exp:order(K), lat:6};

    // Preload while reset is held: 0x11111111..0x44444444 at 2..5, zero elsewhere.
    pl_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      pl_addr = 4'(a);
      pl_dat  = (a >= 2 && a <= 5) ? 32'(32'h11111111 * (a - 1)) : 32'h0;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_block_out", block_out, 0);
    check("rst_mem_r_w", mem_if.mem_r_w, 0);
    check("rst_mem_addr", mem_if.mem_addr, 0);
    check("rst_mem_din", mem_if.mem_din, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // start_write pulsed mid-read must be ignored.
    ord_w  = order(W);
    m8_exp = ord_w[31:0];
    lat = 0;
    @(posedge clk); #1;
    start_read = 1'b1; base_addr = 4'd2;
    @(posedge clk); #1;
    start_read = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      check("midrd_mem_r_w", mem_if.mem_r_w, 0);
      if (c == 2) begin
        start_write = 1'b1; base_addr = 4'd8; block_in = X;
      end
      if (c == 3) start_write = 1'b0;
      if (done) lat = c;
    end
    check("midrd_latency", lat, 6);
    check("midrd_block_out", block_out, order(K));
    check("midrd_mem8", mem[8], m8_exp);
    @(negedge clk);
    check("midrd_idle1", busy, 0);
    @(negedge clk);
    check("midrd_idle2", busy, 0);

    // Reset during the second READ cycle aborts the transfer.
    @(posedge clk); #1;
    start_read = 1'b1; base_addr = 4'd8;
    @(posedge clk); #1;
    start_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_block_out", block_out, 0);
    check("abort_done", done, 0);
    check("abort_mem_r_w", mem_if.mem_r_w, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("abort_no_done", npulse, 0);
    for (int k = 0; k < 4; k++) begin
      check("abort_mem_keep_lo", mem[4'(2 + k)], 32'(32'h11111111 * (k + 1)));
      check("abort_mem_keep_hi", mem[4'(8 + k)], ord_w[k*32 +: 32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
